// File: rtl/ram_arbiter.sv
// Arbitrates the shared single-port data RAM between CPU port C and debug port D.
// Define RAM_ARB_RR_EN for round-robin on contention instead of C priority plus starve counter.
module ram_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1,
  parameter int STARVE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          c_stall
);

  typedef enum logic [1:0] {IDLE, CPU, DBG, LOCK} state_t;

  state_t              r_state;
  logic                w_c_win;
  logic                w_d_win;
  logic                w_push_rd;
  logic                w_tail_v;
  logic [RD_LAT-1:0]   r_pipe_v;
  logic [RD_LAT-1:0]   r_pipe_d;

`ifdef RAM_ARB_RR_EN
  logic                r_rr_c;
`else
  localparam int CW = $clog2(STARVE + 1);
  logic [CW-1:0]       r_starve_cnt;
`endif

  always_comb begin
    w_c_win = 1'b0;
    w_d_win = 1'b0;
    if (rst) begin
      if (r_state == LOCK) begin
        w_d_win = d_req;
      end else begin
`ifdef RAM_ARB_RR_EN
        if (c_req && d_req) begin
          w_c_win = r_rr_c;
          w_d_win = ~r_rr_c;
        end else begin
          w_c_win = c_req;
          w_d_win = d_req;
        end
`else
        if (d_req && (r_starve_cnt == CW'(STARVE))) w_d_win = 1'b1;
        else if (c_req)                              w_c_win = 1'b1;
        else if (d_req)                              w_d_win = 1'b1;
`endif
      end
    end
  end

  assign c_gnt     = w_c_win;
  assign d_gnt     = w_d_win;
  assign c_stall   = rst & c_req & ~w_c_win;
  assign ram_en    = w_c_win | w_d_win;
  assign ram_we    = w_c_win ? c_we    : (w_d_win & d_we);
  assign ram_addr  = w_c_win ? c_addr  : (w_d_win ? d_addr  : '0);
  assign ram_wdata = w_c_win ? c_wdata : (w_d_win ? d_wdata : '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
`ifdef RAM_ARB_RR_EN
      r_rr_c  <= 1'b1;
`else
      r_starve_cnt <= '0;
`endif
    end else begin
      case (r_state)
        LOCK: if (w_d_win && !d_lock) r_state <= DBG;
        default: begin
          if (w_c_win)      r_state <= CPU;
          else if (w_d_win) r_state <= d_lock ? LOCK : DBG;
          else              r_state <= IDLE;
        end
      endcase
`ifdef RAM_ARB_RR_EN
      if ((r_state != LOCK) && c_req && d_req) r_rr_c <= ~r_rr_c;
`else
      if (!d_req || w_d_win)
        r_starve_cnt <= '0;
      else if ((r_state != LOCK) && (r_starve_cnt != CW'(STARVE)))
        r_starve_cnt <= r_starve_cnt + CW'(1);
`endif
    end
  end

  // Tag pipe is as deep as the RAM read latency, so the tail lines up with ram_rdata.
  assign w_push_rd = ram_en & ~ram_we;

  generate
    if (RD_LAT > 1) begin : g_pipe_deep
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_pipe_v <= '0;
          r_pipe_d <= '0;
        end else begin
          r_pipe_v <= {r_pipe_v[RD_LAT-2:0], w_push_rd};
          r_pipe_d <= {r_pipe_d[RD_LAT-2:0], w_d_win};
        end
      end
    end else begin : g_pipe_one
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_pipe_v <= '0;
          r_pipe_d <= '0;
        end else begin
          r_pipe_v <= w_push_rd;
          r_pipe_d <= w_d_win;
        end
      end
    end
  endgenerate

  assign w_tail_v = rst & r_pipe_v[RD_LAT-1];
  assign c_rvalid = w_tail_v & ~r_pipe_d[RD_LAT-1];
  assign d_rvalid = w_tail_v &  r_pipe_d[RD_LAT-1];
  assign c_rdata  = c_rvalid ? ram_rdata : '0;
  assign d_rdata  = d_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter against a rule-level reference model.
module tb_ram_arbiter;
  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;
  localparam int STARVE = 3;

  logic clk = 1'b0;
  logic rst;
  logic c_req, c_we, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr, ram_addr;
  logic [DW-1:0] c_wdata, d_wdata, ram_wdata, ram_rdata, c_rdata, d_rdata;
  logic c_gnt, c_rvalid, d_gnt, d_rvalid, ram_en, ram_we, c_stall;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .c_stall(c_stall)
  );

  // Write-first RAM with RD_LAT read latency; idle cycles put garbage on the data bus.
  logic [DW-1:0] mem   [1<<AW];
  logic [DW-1:0] rline [RD_LAT];
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    rline[0] <= (ram_en && !ram_we) ? mem[ram_addr] : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) rline[i] <= rline[i-1];
  end
  assign ram_rdata = rline[RD_LAT-1];

  typedef struct {
    int            due;
    bit            own_d;
    logic [DW-1:0] data;
  } ret_t;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cycle    = 0;
  int            lost     = 0;
  bit            locked   = 1'b0;
  bit            prefer_c = 1'b1;
  logic [DW-1:0] shadow [1<<AW];
  ret_t          q [$];

  bit            obs_c_gnt, obs_d_gnt, obs_c_stall, obs_c_rvalid, obs_d_rvalid;
  logic [DW-1:0] obs_c_rdata, obs_d_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // One clock: inputs are already set at the falling edge by the caller.
  task automatic step();
    bit            ec, ed, ev_c, ev_d, contended, we;
    logic [AW-1:0] a;
    logic [DW-1:0] edat;
    ret_t          r;
    #1;
    ec = 1'b0;
    ed = 1'b0;
    if (rst) begin
      if (locked) ed = d_req;
`ifdef RAM_ARB_RR_EN
      else if (c_req && d_req) begin ec = prefer_c; ed = !prefer_c; end
`else
      else if (d_req && lost == STARVE) ed = 1'b1;
`endif
      else if (c_req) ec = 1'b1;
      else if (d_req) ed = 1'b1;
    end
    ev_c = 1'b0;
    ev_d = 1'b0;
    edat = '0;
    if (q.size() > 0 && q[0].due == cycle) begin
      r = q.pop_front();
      if (rst) begin
        if (r.own_d) ev_d = 1'b1;
        else         ev_c = 1'b1;
        edat = r.data;
      end
    end
    check("c_gnt",     c_gnt,     ec);
    check("d_gnt",     d_gnt,     ed);
    check("ram_en",    ram_en,    ec | ed);
    check("ram_we",    ram_we,    ec ? c_we : (ed & d_we));
    check("ram_addr",  ram_addr,  ec ? c_addr : (ed ? d_addr : '0));
    check("ram_wdata", ram_wdata, ec ? c_wdata : (ed ? d_wdata : '0));
    check("c_stall",   c_stall,   rst & c_req & !ec);
    check("c_rvalid",  c_rvalid,  ev_c);
    check("c_rdata",   c_rdata,   ev_c ? edat : '0);
    check("d_rvalid",  d_rvalid,  ev_d);
    check("d_rdata",   d_rdata,   ev_d ? edat : '0);
    obs_c_gnt    = c_gnt;
    obs_d_gnt    = d_gnt;
    obs_c_stall  = c_stall;
    obs_c_rvalid = c_rvalid;
    obs_d_rvalid = d_rvalid;
    obs_c_rdata  = c_rdata;
    obs_d_rdata  = d_rdata;
    @(posedge clk);
    if (!rst) begin
      lost     = 0;
      locked   = 1'b0;
      prefer_c = 1'b1;
      q.delete();
    end else begin
      contended = c_req && d_req && !locked;
      if (ec || ed) begin
        a  = ec ? c_addr : d_addr;
        we = ec ? c_we : d_we;
        if (we) shadow[a] = ec ? c_wdata : d_wdata;
        else    q.push_back('{due: cycle + RD_LAT, own_d: ed, data: shadow[a]});
      end
      if (!d_req || ed)                    lost = 0;
      else if (!locked && lost < STARVE)   lost++;
      if (ed)        locked   = d_lock;
      if (contended) prefer_c = !prefer_c;
    end
    cycle++;
    @(negedge clk);
  endtask

  task automatic idle();
    c_req  = 1'b0;
    d_req  = 1'b0;
    d_lock = 1'b0;
  endtask

  initial begin
    int            nd, ns, ic, id, both, t6_rv;
    logic [7:0]    pat, exp_pat;
    logic [DW-1:0] cdat, ddat;

    rst = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
    @(negedge clk);

    // Reset with both requesting, then C wins on release.
    c_req = 1'b1; c_we = 1'b1; d_req = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    check("t1_c_gnt_after_reset", obs_c_gnt, 1);
    check("t1_d_gnt_after_reset", obs_d_gnt, 0);

    // Fill memory through port C.
    d_req = 1'b0;
    for (int i = 0; i < (1 << AW); i++) begin
      c_req = 1'b1; c_we = 1'b1; c_addr = AW'(i); c_wdata = DW'($urandom);
      step();
    end

    // Write then read same address on consecutive cycles.
    c_we = 1'b1; c_addr = AW'(3); c_wdata = 8'hA5;
    step();
    check("t2_wr_gnt", obs_c_gnt, 1);
    c_we = 1'b0;
    step();
    check("t2_rd_gnt", obs_c_gnt, 1);
    idle();
    repeat (RD_LAT) step();
    check("t2_c_rvalid", obs_c_rvalid, 1);
    check("t2_c_rdata",  obs_c_rdata,  8'hA5);
    check("t2_d_rvalid", obs_d_rvalid, 0);

    // Both requesting continuously from a fresh reset.
    rst = 1'b0; step(); rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = AW'(4);
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(5); d_lock = 1'b0;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      pat[i] = obs_d_gnt;
      check("t3_one_grant", obs_c_gnt ^ obs_d_gnt, 1);
    end
`ifdef RAM_ARB_RR_EN
    exp_pat = 8'b1010_1010;
`else
    exp_pat = 8'b1000_1000;
`endif
    check("t3_pattern", pat, exp_pat);

    // D burst under lock while C keeps requesting.
    rst = 1'b0; idle(); step(); rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = AW'(5);
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(0); d_lock = 1'b1;
    obs_d_gnt = 1'b0;
    for (int k = 0; k < 16 && !obs_d_gnt; k++) step();
    check("t4_first_d_gnt", obs_d_gnt, 1);
    nd = int'(obs_d_gnt);
    ns = int'(obs_c_stall);
    for (int a = 1; a <= 3; a++) begin
      d_addr = AW'(a);
      d_lock = (a != 3);
      step();
      nd += int'(obs_d_gnt);
      ns += int'(obs_c_stall);
    end
    d_req = 1'b0; d_lock = 1'b0;
    step();
    check("t4_d_grants",   nd, 4);
    check("t4_stalls",     ns, 4);
    check("t4_c_gnt_after", obs_c_gnt, 1);

    // Alternating owners read back-to-back.
    c_req = 1'b1; c_we = 1'b1; c_addr = AW'(1); c_wdata = 8'h11; step();
    c_addr = AW'(2); c_wdata = 8'h22; step();
    ic = -1; id = -1; both = 0; cdat = '0; ddat = '0;
    for (int s = 0; s < RD_LAT + 2; s++) begin
      idle();
      if (s == 0) begin c_req = 1'b1; c_we = 1'b0; c_addr = AW'(1); end
      if (s == 1) begin d_req = 1'b1; d_we = 1'b0; d_addr = AW'(2); end
      step();
      if (obs_c_rvalid) begin ic = s; cdat = obs_c_rdata; end
      if (obs_d_rvalid) begin id = s; ddat = obs_d_rdata; end
      if (obs_c_rvalid && obs_d_rvalid) both++;
    end
    check("t5_c_ret_cycle", ic, RD_LAT);
    check("t5_d_ret_cycle", id, RD_LAT + 1);
    check("t5_c_data", cdat, 8'h11);
    check("t5_d_data", ddat, 8'h22);
    check("t5_never_both", both, 0);

    // Reset right after a D read is accepted drops the return.
    idle();
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(2);
    step();
    check("t6_d_gnt", obs_d_gnt, 1);
    d_req = 1'b0;
    t6_rv = 0;
    rst = 1'b0;
    repeat (2) begin step(); t6_rv += int'(obs_d_rvalid); end
    rst = 1'b1;
    repeat (RD_LAT + 2) begin step(); t6_rv += int'(obs_d_rvalid); end
    check("t6_no_rvalid", t6_rv, 0);

    // Random traffic; unaccepted requests keep their fields.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      if (!(c_req && !obs_c_gnt)) begin
        c_req   = ($urandom_range(0, 3) != 0);
        c_we    = $urandom_range(0, 1) == 1;
        c_addr  = AW'($urandom);
        c_wdata = DW'($urandom);
      end
      if (!(d_req && !obs_d_gnt)) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = AW'($urandom);
        d_wdata = DW'($urandom);
        d_lock  = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
